// File: rtl/aes_sbox_pkg.sv
// Shared types, SBox tables and lookup helpers for the multi-lane SBox pipeline.
package aes_sbox_pkg;

  localparam int MAX_LANES = 16;

  typedef enum logic [1:0] {
    OP_FWD_LEGACY = 2'b00,
    OP_FWD        = 2'b01,
    OP_INV        = 2'b10,
    OP_ILLEGAL    = 2'b11
  } sbox_op_e;

  // Entry 0 is the most significant byte, so each row reads left to right as in the standard table.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[b];
  endfunction

  // Sized for the widest configuration; unused upper lanes are tied to zero and trimmed.
  typedef struct packed {
    logic [MAX_LANES-1:0][7:0] data;
    logic [MAX_LANES-1:0]      lane_en;
    sbox_op_e                  op;
    logic                      err;
  } stage_t;

endpackage

// File: rtl/aes_sbox_pipe_stage.sv
// One elastic register stage: holds a single transaction, accepts whenever empty or draining.
module aes_sbox_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane AES SBox engine: combinational lookup at the input, then a chain of elastic stages.
module aes_sbox_pipe import aes_sbox_pkg::*; #(
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [NUM_LANES-1:0]   req_lane_en_i,
  input  logic [8*NUM_LANES-1:0] req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [8*NUM_LANES-1:0] rsp_data_o,
  output logic [1:0]             rsp_op_o,
  output logic                   rsp_err_o,
  output logic                   idle_o
);

  localparam int W = $bits(stage_t);

  sbox_op_e                        op;
  logic [NUM_LANES-1:0][7:0]       sub_data;
  stage_t                          pay_in;
  stage_t                          last;
  logic [PIPE_STAGES-1:0]          vld_pipe;
  logic [PIPE_STAGES-1:0]          rdy_pipe;
  logic [PIPE_STAGES-1:0][W-1:0]   pay_pipe;
  logic                            unused_last;

  assign op = sbox_op_e'(req_op_i);

  // Illegal op still substitutes through the forward table; only the err flag differs.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [7:0] b;
    assign b = req_data_i[8*k +: 8];
    assign sub_data[k] = !req_lane_en_i[k] ? b :
                         (op == OP_INV)    ? sbox_inv(b) : sbox_fwd(b);
  end

  always_comb begin
    pay_in                          = '0;
    pay_in.data[NUM_LANES-1:0]      = sub_data;
    pay_in.lane_en[NUM_LANES-1:0]   = req_lane_en_i;
    pay_in.op                       = op;
    pay_in.err                      = (op == OP_ILLEGAL);
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic         in_v;
    logic [W-1:0] in_d;
    logic         out_r;

    if (s == 0) begin : g_first
      assign in_v = req_valid_i;
      assign in_d = pay_in;
    end else begin : g_mid
      assign in_v = vld_pipe[s-1];
      assign in_d = pay_pipe[s-1];
    end

    if (s == PIPE_STAGES-1) begin : g_last
      assign out_r = rsp_ready_i;
    end else begin : g_next
      assign out_r = rdy_pipe[s+1];
    end

    aes_sbox_pipe_stage #(.W(W)) u_stage (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_valid  (in_v),
      .in_ready  (rdy_pipe[s]),
      .in_data   (in_d),
      .out_valid (vld_pipe[s]),
      .out_ready (out_r),
      .out_data  (pay_pipe[s])
    );
  end

  assign last        = pay_pipe[PIPE_STAGES-1];
  assign req_ready_o = rdy_pipe[0];
  assign rsp_valid_o = vld_pipe[PIPE_STAGES-1];
  assign rsp_data_o  = last.data[NUM_LANES-1:0];
  assign rsp_op_o    = last.op;
  assign rsp_err_o   = last.err;
  assign idle_o      = ~|vld_pipe;

  // Lane enables ride along for downstream debug visibility but are not consumed at the output.
  assign unused_last = ^last;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Scoreboard bench for aes_sbox_pipe: driver pushes expected responses, negedge monitor pops and compares.
module tb_aes_sbox_pipe;

  localparam int NL = 4;
  localparam int PS = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_op = 2'b00;
  logic [NL-1:0]   req_en = '0;
  logic [8*NL-1:0] req_data = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [8*NL-1:0] rsp_data;
  logic [1:0]      rsp_op;
  logic            rsp_err;
  logic            idle;

  always #5 clk = ~clk;

  aes_sbox_pipe #(.NUM_LANES(NL), .PIPE_STAGES(PS)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_lane_en_i (req_en),
    .req_data_i    (req_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_op_o      (rsp_op),
    .rsp_err_o     (rsp_err),
    .idle_o        (idle)
  );

  typedef struct {
    logic [8*NL-1:0] data;
    logic [1:0]      op;
    logic            err;
    int              acc;
    bit              lat;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         chk_lat = 1'b0;
  logic [7:0] fwd_t[256];
  logic [7:0] inv_t[256];

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: GF(2^8) inverse followed by the AES affine map.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] ref_fwd(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    s = r ^ rotl1(r) ^ rotl1(rotl1(r)) ^ rotl1(rotl1(rotl1(r))) ^ rotl1(rotl1(rotl1(rotl1(r))));
    return s ^ 8'h63;
  endfunction

  function automatic logic [8*NL-1:0] model(input logic [8*NL-1:0] d, input logic [1:0] op,
                                            input logic [NL-1:0] en);
    logic [8*NL-1:0] r;
    r = d;
    for (int k = 0; k < NL; k++)
      if (en[k]) r[8*k +: 8] = (op == 2'b10) ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [8*NL-1:0] expd, input logic [1:0] op);
    exp_t e;
    e.data = expd;
    e.op   = op;
    e.err  = (op == 2'b11);
    e.acc  = cyc;
    e.lat  = chk_lat;
    sb.push_back(e);
  endtask

  // Call at posedge+1; returns at the next posedge+1 with the request accepted (or timed out).
  task automatic send(input logic [8*NL-1:0] d, input logic [1:0] op, input logic [NL-1:0] en,
                      input logic [8*NL-1:0] expd, input bit must_rdy);
    req_valid = 1'b1;
    req_data  = d;
    req_op    = op;
    req_en    = en;
    @(negedge clk);
    if (must_rdy) chk("req_ready_high", req_ready, 1);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("accept_timeout", 0, 1);
    else push(expd, op);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_data, 0);
        if (rsp_data === '0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got response %h with nothing outstanding", rsp_data);
        end
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_op", rsp_op, e.op);
        chk("rsp_err", rsp_err, e.err);
        if (e.lat) chk("latency", cyc - e.acc, PS);
      end
    end
  end

  logic [8*NL-1:0] bp_d[6];
  logic [1:0]      bp_op[6];
  logic [8*NL-1:0] held_d;
  logic [1:0]      held_op;
  logic            held_err;
  int              acc;

  initial begin
    for (int i = 0; i < 256; i++) fwd_t[i] = ref_fwd(8'(i));
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_idle", idle, 1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // Directed vectors, downstream always ready
    rsp_ready = 1'b1;
    chk_lat   = 1'b1;
    @(posedge clk); #1;
    send(32'hFF530100, 2'b01, 4'hF,    32'h16ED7C63, 1);
    send(32'hFF16ED63, 2'b10, 4'hF,    32'h7DFF5300, 1);
    send(32'h16ED7C63, 2'b10, 4'hF,    32'hFF530100, 1);
    send(32'h11223300, 2'b11, 4'b0101, 32'h11933363, 1);
    send(32'h11223300, 2'b01, 4'b0101, 32'h11933363, 1);
    send(32'h00000001, 2'b00, 4'hF,    32'h6363637C, 1);
    send(32'hA5A5A5A5, 2'b11, 4'h0,    32'hA5A5A5A5, 1);
    drain();

    // Back-pressure: only PS requests fit, output held stable
    chk_lat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_d[i]  = $urandom;
      bp_op[i] = 2'(i % 3);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_data  = bp_d[0];
    req_op    = bp_op[0];
    req_en    = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready && acc < 6) begin
        push(model(bp_d[acc], bp_op[acc], 4'hF), bp_op[acc]);
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 6) begin
        req_data = bp_d[acc];
        req_op   = bp_op[acc];
      end
    end
    @(negedge clk);
    chk("bp_accepted", acc, PS);
    chk("bp_req_ready_low", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_head_data", rsp_data, model(bp_d[0], bp_op[0], 4'hF));
    held_d   = rsp_data;
    held_op  = rsp_op;
    held_err = rsp_err;
    repeat (3) @(negedge clk);
    chk("bp_held_data", rsp_data, held_d);
    chk("bp_held_op", rsp_op, held_op);
    chk("bp_held_err", rsp_err, held_err);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int g = 0; g < 20 && acc < 6; g++) begin
      @(negedge clk);
      chk("bp_accept_while_drain", req_ready, 1);
      chk("bp_throughput", rsp_valid, 1);
      if (req_ready) begin
        push(model(bp_d[acc], bp_op[acc], 4'hF), bp_op[acc]);
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 6) begin
        req_data = bp_d[acc];
        req_op   = bp_op[acc];
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("bp_all_accepted", acc, 6);
    drain();

    // Full-rate random stream
    chk_lat = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      logic [8*NL-1:0] d;
      logic [1:0]      op;
      logic [NL-1:0]   en;
      d  = $urandom;
      op = 2'($urandom_range(0, 3));
      en = NL'($urandom);
      send(d, op, en, model(d, op, en), 1);
    end
    drain();
    chk("idle_after_stream", idle, 1);

    // Asynchronous reset with two transactions in flight
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(32'h01020304, 2'b01, 4'hF, model(32'h01020304, 2'b01, 4'hF), 1);
    send(32'h05060708, 2'b10, 4'hF, model(32'h05060708, 2'b10, 4'hF), 1);
    @(negedge clk);
    chk("inflight_not_idle", idle, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_idle", idle, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    send(32'hFF530100, 2'b01, 4'hF, 32'h16ED7C63, 1);
    drain();
    chk("final_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
